// File: rtl/crc16_check.sv
// Serial CRC-16/CCITT frame checker: payload bits then 16 received CRC bits, MSB-first.
// Flags whether the CRC computed over the payload matches the CRC received after it.
//
// state | meaning
// IDLE  | waiting for start, bit_valid ignored
// DATA  | shifting payload bits through the CRC register
// CRC   | collecting the 16 received CRC bits, crc_calc frozen
// DONE  | result held until the next start
module crc16_check #(
    parameter int DATA_BITS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic        busy,
    output logic        done,
    output logic        crc_ok,
    output logic        crc_err,
    output logic [15:0] crc_calc,
    output logic [15:0] crc_rx
);
    localparam int CW = $clog2(DATA_BITS + 16);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] LAST_CRC  = CW'(DATA_BITS + 15);
    localparam logic [15:0]   POLY      = 16'h1021;

    typedef enum logic [1:0] {IDLE, DATA, CRC, DONE} state_t;

    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic          inv;
    logic [15:0]   crc_next;
    logic [15:0]   rx_next;

    assign inv      = bit_in ^ crc_calc[15];
    assign crc_next = {crc_calc[14:0], 1'b0} ^ (inv ? POLY : 16'h0000);
    assign rx_next  = {crc_rx[14:0], bit_in};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            crc_calc <= 16'h0000;
            crc_rx   <= 16'h0000;
            busy     <= 1'b0;
            done     <= 1'b0;
            crc_ok   <= 1'b0;
            crc_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            // start wins over bit_valid in every state, aborting any frame in flight
            if (start) begin
                state    <= DATA;
                bit_cnt  <= '0;
                crc_calc <= 16'h0000;
                crc_rx   <= 16'h0000;
                busy     <= 1'b1;
                crc_ok   <= 1'b0;
                crc_err  <= 1'b0;
            end else begin
                case (state)
                    DATA: begin
                        if (bit_valid) begin
                            crc_calc <= crc_next;
                            bit_cnt  <= bit_cnt + CW'(1);
                            if (bit_cnt == LAST_DATA) begin
                                state <= CRC;
                            end
                        end
                    end
                    CRC: begin
                        if (bit_valid) begin
                            crc_rx  <= rx_next;
                            bit_cnt <= bit_cnt + CW'(1);
                            // compare against rx_next so the verdict lands with done
                            if (bit_cnt == LAST_CRC) begin
                                state   <= DONE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                crc_ok  <= (crc_calc == rx_next);
                                crc_err <= (crc_calc != rx_next);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_crc16_check.sv
// Randomized bench for crc16_check: two instances (72-bit and 4096-bit payload)
// compared every cycle against a frame-level model using CRC polynomial division.
module tb_crc16_check;
    localparam int NS = 72;
    localparam int NL = 4096;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [1:0] start_v = '0;
    logic [1:0] bit_v = '0;
    logic [1:0] valid_v = '0;
    logic [1:0] busy_v, done_v, ok_v, err_v;
    logic [15:0] calc_v [2];
    logic [15:0] rx_v [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_cyc = 0;
    int dcount [2] = '{0, 0};
    int done_cyc [2] = '{0, 0};

    logic [7:0] pay [512];

    bit          mbits [2][NL+16];
    int          m_n [2] = '{0, 0};
    logic        m_active [2] = '{0, 0};
    logic        m_done [2] = '{0, 0};
    logic        m_ok [2] = '{0, 0};
    logic        m_err [2] = '{0, 0};
    logic [15:0] m_calc [2] = '{16'h0, 16'h0};
    logic [15:0] m_rx [2] = '{16'h0, 16'h0};

    crc16_check #(.DATA_BITS(NS)) dut_s (
        .clk(clk), .reset(reset), .start(start_v[0]), .bit_in(bit_v[0]),
        .bit_valid(valid_v[0]), .busy(busy_v[0]), .done(done_v[0]), .crc_ok(ok_v[0]),
        .crc_err(err_v[0]), .crc_calc(calc_v[0]), .crc_rx(rx_v[0])
    );

    crc16_check #(.DATA_BITS(NL)) dut_l (
        .clk(clk), .reset(reset), .start(start_v[1]), .bit_in(bit_v[1]),
        .bit_valid(valid_v[1]), .busy(busy_v[1]), .done(done_v[1]), .crc_ok(ok_v[1]),
        .crc_err(err_v[1]), .crc_calc(calc_v[1]), .crc_rx(rx_v[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // remainder of M(x)*x^16 divided by x^16+x^12+x^5+1
    function automatic logic [15:0] crc_of(int i, int n);
        logic [16:0] r;
        r = '0;
        for (int k = 0; k < n + 16; k++) begin
            r = {r[15:0], (k < n) ? mbits[i][k] : 1'b0};
            if (r[16]) r = r ^ 17'h11021;
        end
        return r[15:0];
    endfunction

    function automatic logic [15:0] crc_bytes(int nbytes);
        logic [16:0] r;
        r = '0;
        for (int k = 0; k < nbytes * 8 + 16; k++) begin
            r = {r[15:0], (k < nbytes * 8) ? pay[k / 8][7 - (k % 8)] : 1'b0};
            if (r[16]) r = r ^ 17'h11021;
        end
        return r[15:0];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_active[i] = 1'b0; m_n[i] = 0; m_done[i] = 1'b0;
                m_ok[i] = 1'b0; m_err[i] = 1'b0; m_calc[i] = '0; m_rx[i] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_done[i] = 1'b0;
                if (start_v[i]) begin
                    m_active[i] = 1'b1; m_n[i] = 0;
                    m_ok[i] = 1'b0; m_err[i] = 1'b0; m_calc[i] = '0; m_rx[i] = '0;
                end else if (m_active[i] && valid_v[i]) begin
                    mbits[i][m_n[i]] = bit_v[i];
                    m_n[i]++;
                    if (m_n[i] <= ((i == 1) ? NL : NS)) begin
                        m_calc[i] = crc_of(i, m_n[i]);
                    end else begin
                        m_rx[i] = {m_rx[i][14:0], bit_v[i]};
                    end
                    if (m_n[i] == ((i == 1) ? NL : NS) + 16) begin
                        m_active[i] = 1'b0;
                        m_done[i] = 1'b1;
                        m_ok[i] = (m_calc[i] == m_rx[i]);
                        m_err[i] = !m_ok[i];
                    end
                end
            end
        end
    end

    task automatic check(string nm, int i, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t: got %h expected %h", nm, i, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check("busy", i, 32'(busy_v[i]), 32'(m_active[i]));
            check("done", i, 32'(done_v[i]), 32'(m_done[i]));
            check("crc_ok", i, 32'(ok_v[i]), 32'(m_ok[i]));
            check("crc_err", i, 32'(err_v[i]), 32'(m_err[i]));
            check("crc_calc", i, 32'(calc_v[i]), 32'(m_calc[i]));
            check("crc_rx", i, 32'(rx_v[i]), 32'(m_rx[i]));
            if (done_v[i] === 1'b1) begin
                dcount[i]++;
                done_cyc[i] = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_cycles(int i, int n);
        repeat (n) begin
            start_v[i] = 1'b0;
            valid_v[i] = 1'($urandom_range(0, 1));
            bit_v[i] = 1'($urandom_range(0, 1));
            tick();
        end
        valid_v[i] = 1'b0;
    endtask

    task automatic pulse_start(int i);
        start_v[i] = 1'b1;
        valid_v[i] = 1'($urandom_range(0, 1));
        bit_v[i] = 1'($urandom_range(0, 1));
        tick();
        start_v[i] = 1'b0;
        valid_v[i] = 1'b0;
    endtask

    task automatic send_bit(int i, logic b, int gapmax);
        repeat ($urandom_range(0, gapmax)) begin
            valid_v[i] = 1'b0;
            bit_v[i] = 1'($urandom_range(0, 1));
            tick();
        end
        valid_v[i] = 1'b1;
        bit_v[i] = b;
        tick();
        valid_v[i] = 1'b0;
    endtask

    // stop_at < 0 sends the whole frame; otherwise only the first stop_at bits
    task automatic send_frame(int i, int nbytes, logic [15:0] crc, int gapmax, int stop_at);
        int k;
        pulse_start(i);
        first_cyc = cyc;
        k = 0;
        for (int j = 0; j < nbytes * 8; j++) begin
            if (k == stop_at) return;
            send_bit(i, pay[j / 8][7 - (j % 8)], gapmax);
            k++;
        end
        for (int j = 15; j >= 0; j--) begin
            if (k == stop_at) return;
            send_bit(i, crc[j], gapmax);
            k++;
        end
    endtask

    task automatic load_digits();
        for (int b = 0; b < 9; b++) pay[b] = 8'h31 + 8'(b);
    endtask

    task automatic check_cleared(int i, string tag);
        check({tag, "_busy"}, i, 32'(busy_v[i]), 32'd0);
        check({tag, "_done"}, i, 32'(done_v[i]), 32'd0);
        check({tag, "_ok"}, i, 32'(ok_v[i]), 32'd0);
        check({tag, "_err"}, i, 32'(err_v[i]), 32'd0);
        check({tag, "_calc"}, i, 32'(calc_v[i]), 32'd0);
        check({tag, "_rx"}, i, 32'(rx_v[i]), 32'd0);
    endtask

    task automatic check_good_digits(string tag, int d0);
        check({tag, "_calc"}, 0, 32'(calc_v[0]), 32'h31C3);
        check({tag, "_rx"}, 0, 32'(rx_v[0]), 32'h31C3);
        check({tag, "_ok"}, 0, 32'(ok_v[0]), 32'd1);
        check({tag, "_err"}, 0, 32'(err_v[0]), 32'd0);
        check({tag, "_ndone"}, 0, 32'(dcount[0] - d0), 32'd1);
    endtask

    initial begin
        int d0;
        logic [15:0] good;
        logic [15:0] sent;
        int ab;
        bit bad;

        repeat (3) tick();
        check_cleared(0, "rst");
        check_cleared(1, "rst");
        reset = 1'b1;
        idle_cycles(0, 5);
        check_cleared(0, "idle_ignore");

        load_digits();
        d0 = dcount[0];
        send_frame(0, 9, 16'h31C3, 0, -1);
        idle_cycles(0, 4);
        check_good_digits("digits", d0);

        d0 = dcount[0];
        send_frame(0, 9, 16'h31C2, 0, -1);
        idle_cycles(0, 4);
        check("bad_rx", 0, 32'(rx_v[0]), 32'h31C2);
        check("bad_calc", 0, 32'(calc_v[0]), 32'h31C3);
        check("bad_ok", 0, 32'(ok_v[0]), 32'd0);
        check("bad_err", 0, 32'(err_v[0]), 32'd1);
        check("bad_ndone", 0, 32'(dcount[0] - d0), 32'd1);

        d0 = dcount[0];
        send_frame(0, 9, 16'h31C3, 5, -1);
        idle_cycles(0, 4);
        check_good_digits("gaps", d0);

        d0 = dcount[0];
        send_frame(0, 9, 16'h31C3, 0, 40);
        idle_cycles(0, 2);
        check("abort_busy", 0, 32'(busy_v[0]), 32'd1);
        send_frame(0, 9, 16'h31C3, 0, -1);
        idle_cycles(0, 4);
        check_good_digits("abort", d0);

        d0 = dcount[0];
        send_frame(0, 9, 16'h31C3, 0, 80);
        check("crcstate_busy", 0, 32'(busy_v[0]), 32'd1);
        reset = 1'b0;
        tick();
        check_cleared(0, "midrst");
        reset = 1'b1;
        idle_cycles(0, 4);
        check_cleared(0, "postrst");
        send_frame(0, 9, 16'h31C3, 0, -1);
        idle_cycles(0, 4);
        check_good_digits("rstframe", d0);

        for (int f = 0; f < 20; f++) begin
            for (int b = 0; b < 9; b++) pay[b] = 8'($urandom);
            good = crc_bytes(9);
            bad = ($urandom_range(0, 3) == 0);
            sent = bad ? (good ^ (16'h1 << $urandom_range(0, 15))) : good;
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 87)) : -1;
            d0 = dcount[0];
            send_frame(0, 9, sent, 3, ab);
            idle_cycles(0, 3);
            if (ab < 0) begin
                check("rand_ok", 0, 32'(ok_v[0]), 32'(!bad));
                check("rand_ndone", 0, 32'(dcount[0] - d0), 32'd1);
            end else begin
                check("rand_abort_ndone", 0, 32'(dcount[0] - d0), 32'd0);
            end
        end

        for (int b = 0; b < 512; b++) pay[b] = 8'hFF;
        d0 = dcount[1];
        send_frame(1, 512, 16'h7FA1, 0, -1);
        idle_cycles(1, 3);
        check("long_calc", 1, 32'(calc_v[1]), 32'h7FA1);
        check("long_ok", 1, 32'(ok_v[1]), 32'd1);
        check("long_err", 1, 32'(err_v[1]), 32'd0);
        check("long_ndone", 1, 32'(dcount[1] - d0), 32'd1);
        check("long_latency", 1, 32'(done_cyc[1] - first_cyc), 32'd4112);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/crc16_check.md
CRC16_CHECK -- requirements
Module: crc16_check

Interface
REQ-001 SHALL have parameter DATA_BITS, default 4096, giving the number of payload bits per frame (512 bytes); legal range 16..65535.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset; state clears while low.
REQ-004 SHALL have port start  input  1  one-cycle pulse that opens a new frame.
REQ-005 SHALL have port bit_in  input  1  serial frame bit, MSB-first: payload, then 16 received CRC bits.
REQ-006 SHALL have port bit_valid  input  1  qualifies bit_in; one bit is consumed per cycle it is high.
REQ-007 SHALL have port busy  output  1  high from the cycle after start until the frame completes.
REQ-008 SHALL have port done  output  1  one-cycle pulse when the last CRC bit is consumed.
REQ-009 SHALL have port crc_ok  output  1  high when the computed CRC equals the received CRC; valid from done onward.
REQ-010 SHALL have port crc_err  output  1  high when they differ; valid from done onward.
REQ-011 SHALL have port crc_calc  output  16  CRC computed over the payload.
REQ-012 SHALL have port crc_rx  output  16  CRC bits received after the payload.

Function
REQ-013 SHALL compute CRC-16/CCITT, polynomial x^16+x^12+x^5+1 (0x1021), initial value 0x0000, no reflection, no final XOR.
REQ-014 SHALL apply the payload update per valid bit as: inv = bit_in XOR crc_calc[15]; crc_calc = {crc_calc[14:0],0} XOR (inv ? 0x1021 : 0).
REQ-015 SHALL implement states IDLE, DATA, CRC and DONE.
REQ-016 SHALL implement transitions: IDLE/DATA/CRC/DONE --start--> DATA; DATA --DATA_BITS-th valid bit--> CRC; CRC --16th valid bit--> DONE.
REQ-017 SHALL clear crc_calc, crc_rx, the bit counter, crc_ok and crc_err on start.
REQ-018 SHALL count valid bits with a counter of width clog2(DATA_BITS+16), reset to 0 on start.
REQ-019 SHALL shift bit_in into crc_rx[0] in state CRC, each bit moving the previous contents left (MSB-first), and SHALL freeze crc_calc in that state.
REQ-020 SHALL, on the cycle the 16th CRC bit is registered, enter DONE, pulse done for exactly one cycle, and set crc_ok = (crc_calc == final crc_rx) and crc_err = its complement.
REQ-021 SHALL hold crc_ok, crc_err, crc_calc and crc_rx in DONE until the next start or reset.
REQ-022 SHALL drive busy high in states DATA and CRC only.
REQ-023 SHALL ignore bit_valid in IDLE and DONE.
REQ-024 SHALL give priority to start when start and bit_valid are high in the same cycle: the bit is discarded and the frame restarts.
REQ-025 SHALL abort the current frame on start in DATA or CRC, with no done pulse, and restart cleanly.
REQ-026 SHALL leave the state unchanged on gaps in bit_valid (stalls of any length).

Reset
REQ-027 SHALL, while reset is low, force state IDLE, counter 0, crc_calc 0x0000, crc_rx 0x0000, busy 0, done 0, crc_ok 0, crc_err 0.
REQ-028 SHALL, when reset asserts mid-frame, discard the frame with no done pulse, and SHALL then wait in IDLE for start.

Verification
REQ-029 SHALL cover: DATA_BITS=4096, 512 bytes 0xFF, then CRC 0x7FA1, continuous valid -> crc_calc=0x7FA1, crc_ok=1, done 4112 cycles after the first valid bit.
REQ-030 SHALL cover: DATA_BITS=72, ASCII "123456789", then 0x31C3 -> crc_calc=0x31C3, crc_ok=1, crc_err=0.
REQ-031 SHALL cover: same as REQ-030 but trailing CRC 0x31C2 -> crc_rx=0x31C2, crc_ok=0, crc_err=1, done pulses once.
REQ-032 SHALL cover: REQ-030 stream with random bit_valid gaps (up to 5 idle cycles) -> identical results to REQ-030.
REQ-033 SHALL cover: start at bit 40 of a frame, then a full REQ-030 frame -> no done for the aborted frame, crc_ok=1 for the second.
REQ-034 SHALL cover: reset low during CRC state, then released and REQ-030 frame -> outputs at reset values until start, then crc_ok=1.
